// File: rtl/fwrisc_fetch.sv
// Instruction-fetch stage: fetches 32-bit words, splits out RV32C halfwords,
// stitches word-straddling instructions and hands one instruction at a time to decode.
module fwrisc_fetch #(
  parameter logic [31:0] RESET_VECTOR      = 32'h0000_0000,
  parameter bit          ENABLE_COMPRESSED = 1'b1
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] next_pc,
  input  logic        next_pc_valid,
  output logic [31:0] ibus_adr,
  output logic        ibus_req,
  input  logic [31:0] ibus_rdata,
  input  logic        ibus_ack,
  output logic        fetch_valid,
  input  logic        decode_ready,
  output logic [31:0] instr,
  output logic        instr_c,
  output logic [31:0] pc
);

  typedef enum logic [2:0] {
    BOOT,
    IDLE,
    REQ_LO,
    REQ_HI,
    VALID
  } state_t;

  state_t      r_state;
  logic [31:0] r_adr;
  logic        r_req;
  logic        r_valid;
  logic [31:0] r_instr;
  logic        r_instrC;
  logic [31:0] r_pc;
  logic [15:0] r_hbuf;

  logic w_hiHalf;
  logic w_loIsC;
  logic w_hiIsC;

  // With compression disabled every instruction is a full aligned word.
  assign w_hiHalf = ENABLE_COMPRESSED && r_pc[1];
  assign w_loIsC  = ENABLE_COMPRESSED && (ibus_rdata[1:0] != 2'b11);
  assign w_hiIsC  = (ibus_rdata[17:16] != 2'b11);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state  <= BOOT;
      r_adr    <= 32'h0;
      r_req    <= 1'b0;
      r_valid  <= 1'b0;
      r_instr  <= 32'h0;
      r_instrC <= 1'b0;
      r_pc     <= RESET_VECTOR;
      r_hbuf   <= 16'h0;
    end else begin
      case (r_state)
        BOOT: begin
          r_req   <= 1'b1;
          r_adr   <= {r_pc[31:2], 2'b00};
          r_state <= REQ_LO;
        end
        IDLE: begin
          if (next_pc_valid) begin
            r_pc    <= next_pc & ~32'h1;
            r_req   <= 1'b1;
            r_adr   <= {next_pc[31:2], 2'b00};
            r_state <= REQ_LO;
          end
        end
        REQ_LO: begin
          if (ibus_ack) begin
            if (!w_hiHalf) begin
              r_instr  <= w_loIsC ? {16'h0, ibus_rdata[15:0]} : ibus_rdata;
              r_instrC <= w_loIsC;
              r_req    <= 1'b0;
              r_valid  <= 1'b1;
              r_state  <= VALID;
            end else if (w_hiIsC) begin
              r_instr  <= {16'h0, ibus_rdata[31:16]};
              r_instrC <= 1'b1;
              r_req    <= 1'b0;
              r_valid  <= 1'b1;
              r_state  <= VALID;
            end else begin
              // Upper halfword starts a 32-bit instruction; keep the bus request up for the next word.
              r_hbuf  <= ibus_rdata[31:16];
              r_adr   <= r_adr + 32'd4;
              r_state <= REQ_HI;
            end
          end
        end
        REQ_HI: begin
          if (ibus_ack) begin
            r_instr  <= {ibus_rdata[15:0], r_hbuf};
            r_instrC <= 1'b0;
            r_req    <= 1'b0;
            r_valid  <= 1'b1;
            r_state  <= VALID;
          end
        end
        VALID: begin
          if (decode_ready) begin
            r_valid <= 1'b0;
            r_state <= IDLE;
          end
        end
        default: begin
          r_req   <= 1'b0;
          r_valid <= 1'b0;
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign ibus_adr    = r_adr;
  assign ibus_req    = r_req;
  assign fetch_valid = r_valid;
  assign instr       = r_instr;
  assign instr_c     = r_instrC;
  assign pc          = r_pc;

endmodule

// File: tb/tb_fwrisc_fetch.sv
// Directed testbench for fwrisc_fetch: word, compressed, straddle, wrap, backpressure and reset cases.
module tb_fwrisc_fetch;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic [31:0] next_pc = '0;
  logic        next_pc_valid = 1'b0;
  logic [31:0] ibus_adr;
  logic        ibus_req;
  logic [31:0] ibus_rdata = '0;
  logic        ibus_ack = 1'b0;
  logic        fetch_valid;
  logic        decode_ready = 1'b0;
  logic [31:0] instr;
  logic        instr_c;
  logic [31:0] pc;

  int vectors = 0;
  int miscompares = 0;

  fwrisc_fetch #(.RESET_VECTOR(32'h0000_0000), .ENABLE_COMPRESSED(1'b1)) dut (
    .clock(clock), .reset(reset), .next_pc(next_pc), .next_pc_valid(next_pc_valid),
    .ibus_adr(ibus_adr), .ibus_req(ibus_req), .ibus_rdata(ibus_rdata), .ibus_ack(ibus_ack),
    .fetch_valid(fetch_valid), .decode_ready(decode_ready), .instr(instr), .instr_c(instr_c),
    .pc(pc)
  );

  always #5 clock = ~clock;

  // Drivers are entered and left on a falling edge.
  task automatic startFetch(input logic [31:0] target);
    next_pc = target;
    next_pc_valid = 1'b1;
    @(negedge clock);
    next_pc_valid = 1'b0;
  endtask

  task automatic serveReq(input logic [31:0] data, output logic [31:0] adr, output bit ok);
    ok = 1'b0;
    adr = '0;
    for (int i = 0; i < 20; i++) begin
      if (ibus_req === 1'b1) begin
        ok = 1'b1;
        break;
      end
      @(negedge clock);
    end
    if (ok) begin
      adr = ibus_adr;
      ibus_ack = 1'b1;
      ibus_rdata = data;
      @(negedge clock);
      ibus_ack = 1'b0;
      ibus_rdata = '0;
    end
  endtask

  task automatic acceptInstr();
    decode_ready = 1'b1;
    @(negedge clock);
    decode_ready = 1'b0;
  endtask

  task automatic test_reset();
    ibus_ack = 1'b1;
    ibus_rdata = 32'h0050_0093;
    @(negedge clock);
    vectors++;
    if ({ibus_req, fetch_valid, instr_c, ibus_adr, instr, pc} !== {3'b000, 32'h0, 32'h0, 32'h0}) begin
      miscompares++;
      $display("[TB] FAIL reset_values: got req=%b valid=%b c=%b adr=%h instr=%h pc=%h expected all zero",
               ibus_req, fetch_valid, instr_c, ibus_adr, instr, pc);
    end
  endtask

  task automatic test_boot_fetch();
    reset = 1'b1;
    @(negedge clock);
    vectors++;
    if ({ibus_req, ibus_adr} !== {1'b1, 32'h0}) begin
      miscompares++;
      $display("[TB] FAIL boot_req: got req=%b adr=%h expected req=1 adr=00000000", ibus_req, ibus_adr);
    end
    @(negedge clock);
    ibus_ack = 1'b0;
    ibus_rdata = '0;
    vectors++;
    if ({fetch_valid, ibus_req, instr_c, instr, pc} !== {3'b100, 32'h0050_0093, 32'h0}) begin
      miscompares++;
      $display("[TB] FAIL boot_instr: got v=%b req=%b c=%b instr=%h pc=%h expected v=1 req=0 c=0 instr=00500093 pc=0",
               fetch_valid, ibus_req, instr_c, instr, pc);
    end
    acceptInstr();
    vectors++;
    if (fetch_valid !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL boot_accept: got valid=%b expected 0", fetch_valid);
    end
  endtask

  task automatic test_single(input string name, input logic [31:0] target, input logic [31:0] data,
                             input logic [31:0] expAdr, input logic [31:0] expInstr, input logic expC);
    logic [31:0] adr;
    bit ok;
    startFetch(target);
    serveReq(data, adr, ok);
    vectors++;
    if (!ok || adr !== expAdr) begin
      miscompares++;
      $display("[TB] FAIL %s_adr: got ok=%0d adr=%h expected ok=1 adr=%h", name, ok, adr, expAdr);
    end
    vectors++;
    if ({fetch_valid, ibus_req, instr_c, instr, pc} !== {1'b1, 1'b0, expC, expInstr, target}) begin
      miscompares++;
      $display("[TB] FAIL %s_instr: got v=%b req=%b c=%b instr=%h pc=%h expected v=1 req=0 c=%b instr=%h pc=%h",
               name, fetch_valid, ibus_req, instr_c, instr, pc, expC, expInstr, target);
    end
    acceptInstr();
  endtask

  task automatic test_straddle(input string name, input logic [31:0] target, input logic [31:0] data0,
                               input logic [31:0] data1, input logic [31:0] expAdr0,
                               input logic [31:0] expAdr1, input logic [31:0] expInstr);
    logic [31:0] adr;
    bit ok;
    startFetch(target);
    serveReq(data0, adr, ok);
    vectors++;
    if (!ok || adr !== expAdr0 || ibus_req !== 1'b1 || fetch_valid !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL %s_first: got ok=%0d adr=%h req=%b v=%b expected ok=1 adr=%h req=1 v=0",
               name, ok, adr, ibus_req, fetch_valid, expAdr0);
    end
    serveReq(data1, adr, ok);
    vectors++;
    if (!ok || adr !== expAdr1) begin
      miscompares++;
      $display("[TB] FAIL %s_second: got ok=%0d adr=%h expected ok=1 adr=%h", name, ok, adr, expAdr1);
    end
    vectors++;
    if ({fetch_valid, ibus_req, instr_c, instr, pc} !== {3'b100, expInstr, target}) begin
      miscompares++;
      $display("[TB] FAIL %s_instr: got v=%b req=%b c=%b instr=%h pc=%h expected v=1 req=0 c=0 instr=%h pc=%h",
               name, fetch_valid, ibus_req, instr_c, instr, pc, expInstr, target);
    end
    acceptInstr();
  endtask

  task automatic test_back_pressure();
    logic [31:0] adr;
    bit ok;
    startFetch(32'h300);
    serveReq(32'h00A0_0113, adr, ok);
    for (int i = 0; i < 5; i++) begin
      if (i == 1) begin
        next_pc = 32'h400;
        next_pc_valid = 1'b1;
      end else begin
        next_pc_valid = 1'b0;
      end
      vectors++;
      if ({ok, fetch_valid, ibus_req, instr, pc} !== {3'b110, 32'h00A0_0113, 32'h300}) begin
        miscompares++;
        $display("[TB] FAIL hold_%0d: got ok=%0d v=%b req=%b instr=%h pc=%h expected ok=1 v=1 req=0 instr=00a00113 pc=00000300",
                 i, ok, fetch_valid, ibus_req, instr, pc);
      end
      @(negedge clock);
    end
    next_pc_valid = 1'b0;
    acceptInstr();
    vectors++;
    if ({fetch_valid, ibus_req} !== 2'b00) begin
      miscompares++;
      $display("[TB] FAIL hold_release: got v=%b req=%b expected 0 0", fetch_valid, ibus_req);
    end
    @(negedge clock);
    vectors++;
    if ({ibus_req, pc} !== {1'b0, 32'h300}) begin
      miscompares++;
      $display("[TB] FAIL hold_no_queue: got req=%b pc=%h expected req=0 pc=00000300", ibus_req, pc);
    end
  endtask

  task automatic test_reset_mid_fetch();
    logic [31:0] adr;
    bit ok;
    startFetch(32'h206);
    serveReq(32'h0093_BEEF, adr, ok);
    #2;
    reset = 1'b0;
    ibus_ack = 1'b1;
    ibus_rdata = 32'hFFFF_FFFF;
    #1;
    vectors++;
    if ({ok, ibus_req, fetch_valid, ibus_adr, pc} !== {3'b100, 32'h0, 32'h0}) begin
      miscompares++;
      $display("[TB] FAIL async_reset: got ok=%0d req=%b v=%b adr=%h pc=%h expected ok=1 req=0 v=0 adr=0 pc=0",
               ok, ibus_req, fetch_valid, ibus_adr, pc);
    end
    @(negedge clock);
    vectors++;
    if ({ibus_req, fetch_valid, instr_c, instr} !== {3'b000, 32'h0}) begin
      miscompares++;
      $display("[TB] FAIL reset_ack_ignored: got req=%b v=%b c=%b instr=%h expected 0 0 0 00000000",
               ibus_req, fetch_valid, instr_c, instr);
    end
    ibus_ack = 1'b0;
    ibus_rdata = '0;
    reset = 1'b1;
    @(negedge clock);
    serveReq(32'h0000_0513, adr, ok);
    vectors++;
    if ({ok, adr, fetch_valid, instr_c, instr, pc} !== {1'b1, 32'h0, 2'b10, 32'h0000_0513, 32'h0}) begin
      miscompares++;
      $display("[TB] FAIL restart: got ok=%0d adr=%h v=%b c=%b instr=%h pc=%h expected 1 0 1 0 00000513 0",
               ok, adr, fetch_valid, instr_c, instr, pc);
    end
    acceptInstr();
  endtask

  initial begin
    test_reset();
    test_boot_fetch();
    test_single("cmp_lo", 32'h100, 32'hABCD_4501, 32'h100, 32'h0000_4501, 1'b1);
    test_single("cmp_hi", 32'h102, 32'h4505_1234, 32'h100, 32'h0000_4505, 1'b1);
    test_single("word", 32'h180, 32'h0010_0073, 32'h180, 32'h0010_0073, 1'b0);
    test_straddle("straddle", 32'h206, 32'h0093_BEEF, 32'hDEAD_0050, 32'h204, 32'h208, 32'h0050_0093);
    test_straddle("wrap", 32'hFFFF_FFFE, 32'h0013_0000, 32'h0000_0000, 32'hFFFF_FFFC, 32'h0, 32'h0000_0013);
    test_back_pressure();
    test_reset_mid_fetch();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/fwrisc_fetch.md
Name: fwrisc_fetch

Overview:
Instruction-fetch stage directly upstream of the decode stage. Fetches 32-bit words over a simple request/acknowledge instruction bus and identifies 16-bit compressed instructions. Assembles instructions that straddle a word boundary and presents one instruction at a time to decode over a valid/ready handshake. Execute supplies the PC of the next instruction.

Parameters:
RESET_VECTOR, 32'h0000_0000, PC of the first fetch after reset.
ENABLE_COMPRESSED, 1, 1 = RV32C halfword-aligned fetch; 0 = all instructions 32-bit; pc[1] is assumed 0 and ignored.

Ports:
clock  input  1  single clock, rising edge.
reset  input  1  asynchronous, active-low reset.
next_pc  input  32  PC of the next instruction; ignored bit 0.
next_pc_valid  input  1  next_pc is valid; sampled only in IDLE.
ibus_adr  output  32  word-aligned bus address; [1:0] always 0.
ibus_req  output  1  bus request.
ibus_rdata  input  32  read data; valid when ibus_ack=1.
ibus_ack  input  1  transfer complete; only meaningful while ibus_req=1.
fetch_valid  output  1  instr, instr_c and pc are valid for decode.
decode_ready  input  1  decode accepts the instruction.
instr  output  32  instruction; compressed instructions are zero-extended in [15:0].
instr_c  output  1  1 = instr is a 16-bit compressed instruction.
pc  output  32  PC of the presented instruction.

Behaviour:
- All outputs are registered.
- Reset (reset=0, asynchronous) values:
  - state=BOOT, fetch_valid=0, ibus_req=0, ibus_adr=0.
  - instr=0, instr_c=0, pc=RESET_VECTOR.
  - Internal halfword buffer hbuf=0.
- Reset asserted mid-transfer abandons the transfer immediately. An ack arriving while reset is asserted is ignored.
- BOOT -> REQ_LO on the first clock after reset release: ibus_req<=1, ibus_adr<={pc[31:2],2'b00}.
- IDLE: on next_pc_valid=1 -> REQ_LO with pc<={next_pc[31:1],1'b0}, ibus_req<=1, ibus_adr<={next_pc[31:2],2'b00}. Otherwise IDLE is held.
- REQ_LO: ibus_req and ibus_adr are held stable until ibus_ack=1. On ack, with w=ibus_rdata:
  - pc[1]=0, w[1:0]!=2'b11, ENABLE_COMPRESSED=1: instr<={16'h0,w[15:0]}, instr_c<=1 -> VALID.
  - pc[1]=0, otherwise: instr<=w, instr_c<=0 -> VALID.
  - pc[1]=1, w[17:16]!=2'b11: instr<={16'h0,w[31:16]}, instr_c<=1 -> VALID.
  - pc[1]=1, w[17:16]=2'b11: hbuf<=w[31:16], ibus_adr<=ibus_adr+4, ibus_req stays 1 -> REQ_HI. No idle cycle between the two requests.
- REQ_HI: on ack: instr<={ibus_rdata[15:0],hbuf}, instr_c<=0 -> VALID. ibus_adr wraps 32'hFFFF_FFFC -> 0 modulo 2^32.
- On every transition to VALID: ibus_req<=0, fetch_valid<=1.
- VALID: instr, instr_c and pc are held stable while decode_ready=0. On decode_ready=1: fetch_valid<=0 -> IDLE.
- Latency:
  - Ack in cycle N -> fetch_valid=1 in cycle N+1.
  - The earliest next request is the cycle after IDLE samples next_pc_valid.
- next_pc_valid outside IDLE is ignored; no queuing.
- decode_ready outside VALID is ignored.
- ibus_ack while ibus_req=0 is ignored.
- When ENABLE_COMPRESSED=0, REQ_HI is unreachable and instr_c is constant 0.

Test Plan:
1. Reset release, RESET_VECTOR=0, ack in the same cycle with rdata=32'h00500093 -> ibus_adr=0; next cycle fetch_valid=1, instr=32'h00500093, instr_c=0, pc=0.
2. next_pc=32'h100, rdata=32'hABCD4501 -> instr=32'h00004501, instr_c=1, pc=32'h100.
3. next_pc=32'h102, rdata=32'h4505_xxxx -> single request at adr 32'h100; instr=32'h00004505, instr_c=1, pc=32'h102.
4. Straddle: next_pc=32'h206:
   - rdata0=32'h0093_xxxx at adr 32'h204, then rdata1=32'hxxxx_0050 at adr 32'h208.
   - ibus_req stays high for both requests; instr=32'h00500093, instr_c=0, pc=32'h206.
5. Backpressure: decode_ready held 0 for 5 cycles in VALID -> fetch_valid, instr and pc stable for all 5 cycles; next_pc_valid pulsed then is ignored. After decode_ready=1, fetch_valid=0 and state is IDLE.
6. Reset asserted in REQ_HI -> ibus_req=0 and fetch_valid=0 immediately. After release, the fetch restarts at RESET_VECTOR with no stale hbuf.
